// File: rtl/tea_pkg.sv
// Shared constants and FSM state type for the TEA receive-side decipher.
package tea_pkg;

    localparam int          TEA_WORD_SIZE    = 32;
    localparam logic [31:0] TEA_DELTA        = 32'h9e3779b9;
    localparam int          TEA_ROUND_NUMBER = 32;

    // Decipher starts from the sum the cipher ends on: DELTA*ROUNDS mod 2^32.
    localparam logic [31:0] TEA_INIT_SUM =
        32'(64'(TEA_DELTA) * 64'(TEA_ROUND_NUMBER));

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_ROUND,
        ST_EMIT
    } tea_state_e;

endpackage

// File: rtl/tea_round_dec.sv
// One combinational TEA decipher round. v1 is unwound first, then v0 using
// the freshly computed v1, mirroring the cipher's update order in reverse.
module tea_round_dec #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] v0,
    input  logic [WORD_SIZE-1:0] v1,
    input  logic [WORD_SIZE-1:0] sum,
    input  logic [WORD_SIZE-1:0] k0,
    input  logic [WORD_SIZE-1:0] k1,
    input  logic [WORD_SIZE-1:0] k2,
    input  logic [WORD_SIZE-1:0] k3,
    output logic [WORD_SIZE-1:0] v0_next,
    output logic [WORD_SIZE-1:0] v1_next
);

    // All arithmetic wraps at WORD_SIZE; shifts are logical on unsigned words.
    always_comb begin
        v1_next = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        v0_next = v0 - (((v1_next << 4) + k0) ^ (v1_next + sum) ^ ((v1_next >> 5) + k1));
    end

endmodule

// File: rtl/tea_rx_decrypt.sv
// Byte-stream TEA decryptor: collects a ciphertext block byte by byte,
// runs one decipher round per clock, then streams the plaintext out.
module tea_rx_decrypt
    import tea_pkg::*;
#(
    parameter int                   WORD_SIZE    = TEA_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] DELTA        = TEA_DELTA,
    parameter int                   ROUND_NUMBER = TEA_ROUND_NUMBER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    input  logic [7:0]           iRxData,
    input  logic                 iRxValid,
    output logic                 oRxReady,
    output logic [7:0]           oTxData,
    output logic                 oTxValid,
    input  logic                 iTxReady,
    output logic                 oBusy
);

    localparam int BLK_W       = 2 * WORD_SIZE;
    localparam int BLOCK_BYTES = BLK_W / 8;
    localparam int BC_W        = $clog2(BLOCK_BYTES);
    localparam int RC_W        = $clog2(ROUND_NUMBER + 1);

    localparam logic [BC_W-1:0] LAST_BYTE  = BC_W'(BLOCK_BYTES - 1);
    localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(ROUND_NUMBER - 1);

    // Starting sum follows the parameters so overrides stay self-consistent.
    localparam logic [WORD_SIZE-1:0] SUM_INIT =
        WORD_SIZE'(BLK_W'(DELTA) * BLK_W'(ROUND_NUMBER));

    tea_state_e state;

    // blk holds {v0, v1}; it is the input shifter, the round state and the
    // output shifter in turn, so the top byte is always the next one to move.
    logic [BLK_W-1:0]     blk;
    logic [WORD_SIZE-1:0] sum;
    logic [WORD_SIZE-1:0] k0_q, k1_q, k2_q, k3_q;
    logic [BC_W-1:0]      byte_cnt;
    logic [RC_W-1:0]      round_cnt;

    logic [WORD_SIZE-1:0] v0_next, v1_next;

    tea_round_dec #(
        .WORD_SIZE (WORD_SIZE)
    ) u_round (
        .v0      (blk[BLK_W-1:WORD_SIZE]),
        .v1      (blk[WORD_SIZE-1:0]),
        .sum     (sum),
        .k0      (k0_q),
        .k1      (k1_q),
        .k2      (k2_q),
        .k3      (k3_q),
        .v0_next (v0_next),
        .v1_next (v1_next)
    );

    // Main FSM with registered handshake outputs; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_COLLECT;
            blk       <= '0;
            sum       <= '0;
            k0_q      <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            k3_q      <= '0;
            byte_cnt  <= '0;
            round_cnt <= '0;
            oRxReady  <= 1'b1;
            oTxValid  <= 1'b0;
            oTxData   <= '0;
            oBusy     <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (iRxValid && oRxReady) begin
                        blk <= {blk[BLK_W-9:0], iRxData};
                        if (byte_cnt == LAST_BYTE) begin
                            // Key is captured here so later key edits cannot
                            // disturb the block being deciphered.
                            state     <= ST_ROUND;
                            sum       <= SUM_INIT;
                            k0_q      <= iK0;
                            k1_q      <= iK1;
                            k2_q      <= iK2;
                            k3_q      <= iK3;
                            byte_cnt  <= '0;
                            round_cnt <= '0;
                            oRxReady  <= 1'b0;
                            oBusy     <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                ST_ROUND: begin
                    blk       <= {v0_next, v1_next};
                    sum       <= sum - DELTA;
                    round_cnt <= round_cnt + 1'b1;
                    if (round_cnt == LAST_ROUND) begin
                        // First plaintext byte is presented on the same edge
                        // that finishes the last round.
                        state    <= ST_EMIT;
                        oTxValid <= 1'b1;
                        oTxData  <= v0_next[WORD_SIZE-1 -: 8];
                    end
                end

                ST_EMIT: begin
                    if (oTxValid && iTxReady) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= ST_COLLECT;
                            byte_cnt <= '0;
                            oTxValid <= 1'b0;
                            oRxReady <= 1'b1;
                            oBusy    <= 1'b0;
                        end else begin
                            blk      <= {blk[BLK_W-9:0], 8'h00};
                            oTxData  <= blk[BLK_W-9 -: 8];
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= ST_COLLECT;
                    oRxReady <= 1'b1;
                    oTxValid <= 1'b0;
                    oBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_rx_decrypt.sv
// Scoreboard bench for tea_rx_decrypt: stimulus pushes expected plaintext
// bytes, a negedge monitor pops and compares every output handshake.
module tb_tea_rx_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iK0, iK1, iK2, iK3;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady;
    logic        oBusy;

    tea_rx_decrypt dut (
        .clk      (clk),
        .rst      (rst),
        .iK0      (iK0),
        .iK1      (iK1),
        .iK2      (iK2),
        .iK3      (iK3),
        .iRxData  (iRxData),
        .iRxValid (iRxValid),
        .oRxReady (oRxReady),
        .oTxData  (oTxData),
        .oTxValid (oTxValid),
        .iTxReady (iTxReady),
        .oBusy    (oBusy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx_count = 0;
    int in_blk = 0;
    int last_acc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    localparam logic [63:0] KNOWN_CT = 64'h41EA3A0A_94BAA940;
    localparam logic [63:0] RT_PT    = 64'h3d45f7a7_235fcb21;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference TEA cipher, used only to produce ciphertext stimulus.
    function automatic logic [63:0] tea_enc(input logic [63:0] v, input logic [31:0] k0,
                                            input logic [31:0] k1, input logic [31:0] k2,
                                            input logic [31:0] k3);
        logic [31:0] y, z, s;
        y = v[63:32];
        z = v[31:0];
        s = 32'h0;
        for (int i = 0; i < 32; i++) begin
            s = s + 32'h9e3779b9;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        end
        return {y, z};
    endfunction

    // Monitor: everything sampled at negedge, describing the coming posedge.
    always @(negedge clk) begin
        if (rst) begin
            in_blk     = 0;
            prev_valid = 1'b0;
        end else begin
            if (iRxValid && oRxReady) begin
                rx_count++;
                if (in_blk == 7) begin
                    last_acc = cyc + 1;
                    in_blk   = 0;
                end else begin
                    in_blk++;
                end
            end
            if (oTxValid && !prev_valid)
                check("latency", 64'(cyc - last_acc), 64'd32);
            prev_valid = oTxValid;
            if (oTxValid && iTxReady) begin
                if (exp_q.size() == 0)
                    fail_now($sformatf("unexpected_tx got %0h", oTxData));
                else
                    check("tx_byte", 64'(oTxData), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        iRxData  = b;
        iRxValid = 1'b1;
        @(negedge clk);
        while (!oRxReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!oRxReady) fail_now("rx_ready_timeout");
        @(posedge clk);
        #1;
        iRxValid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] ct, input logic [31:0] k0, input logic [31:0] k1,
                              input logic [31:0] k2, input logic [31:0] k3, input bit gapped);
        iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
        for (int i = 0; i < 8; i++) begin
            send_byte(ct[63-8*i -: 8]);
            if (gapped && i != 7) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_block(input logic [63:0] pt);
        for (int i = 0; i < 8; i++) exp_q.push_back(pt[63-8*i -: 8]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now({name, "_drain_timeout"});
            exp_q.delete();
        end else begin
            check({name, "_rx_ready_after"}, 64'(oRxReady), 64'd1);
            check({name, "_busy_after"}, 64'(oBusy), 64'd0);
            check({name, "_valid_after"}, 64'(oTxValid), 64'd0);
        end
    endtask

    logic [63:0] rt_ct;
    int rx_before;
    int wn;

    initial begin
        rst = 1'b1; iRxValid = 1'b0; iRxData = 8'h00; iTxReady = 1'b1;
        iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_rx_ready", 64'(oRxReady), 64'd1);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_tx_valid", 64'(oTxValid), 64'd0);
        check("rst_tx_data", 64'(oTxData), 64'd0);
        @(posedge clk); #1;

        // Known all-zero-key vector.
        push_block(64'h0);
        send_block(KNOWN_CT, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("known_busy_in_round", 64'(oBusy), 64'd1);
        check("known_rx_ready_in_round", 64'(oRxReady), 64'd0);
        drain("known");

        // Round trip through the reference cipher.
        rt_ct = tea_enc(RT_PT, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235);
        push_block(RT_PT);
        send_block(rt_ct, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235, 1'b0);
        drain("roundtrip");

        // Backpressure: hold the first plaintext byte for 10 cycles.
        iTxReady = 1'b0;
        push_block(RT_PT);
        send_block(rt_ct, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235, 1'b0);
        wn = 0;
        while (!oTxValid && wn < 100) begin
            @(posedge clk); #2;
            wn++;
        end
        if (!oTxValid) fail_now("bp_valid_timeout");
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_held", 64'(oTxValid), 64'd1);
            check("bp_data_held", 64'(oTxData), 64'h3d);
            check("bp_rx_ready", 64'(oRxReady), 64'd0);
        end
        @(posedge clk); #1;
        iTxReady = 1'b1;
        drain("backpressure");

        // Gapped input stream.
        rx_before = rx_count;
        push_block(64'h0);
        send_block(KNOWN_CT, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        drain("gapped");
        check("gapped_transfers", 64'(rx_count - rx_before), 64'd8);

        // Reset after 10 rounds; nothing from that block may appear.
        send_block(KNOWN_CT, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", 64'(oBusy), 64'd0);
        check("abort_rx_ready", 64'(oRxReady), 64'd1);
        check("abort_tx_valid", 64'(oTxValid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        push_block(64'h0);
        send_block(KNOWN_CT, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        drain("after_abort");

        // Key altered mid-ROUND must not affect the result.
        push_block(64'h0);
        send_block(KNOWN_CT, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        iK0 = 32'hdeadbeef; iK1 = 32'h01234567; iK2 = 32'h89abcdef; iK3 = 32'hfeedface;
        drain("keychange");
        iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tea_rx_decrypt.md
TEA_RX_DECRYPT -- requirements
Module: tea_rx_decrypt

Interface
REQ-001 Parameter WORD_SIZE, default 32: TEA half-block and key word width.
REQ-002 Parameter DELTA, default 32'h9e3779b9: TEA key-schedule constant.
REQ-003 Parameter ROUND_NUMBER, default 32: number of decipher rounds per block.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Ports iK0, iK1, iK2, iK3, input, WORD_SIZE each: decryption key words.
REQ-007 Port iRxData, input, 8: ciphertext byte in.
REQ-008 Port iRxValid, input, 1: iRxData is valid.
REQ-009 Port oRxReady, output, 1: block accepts a byte this cycle.
REQ-010 Port oTxData, output, 8: plaintext byte out.
REQ-011 Port oTxValid, output, 1: oTxData is valid.
REQ-012 Port iTxReady, input, 1: downstream accepts oTxData this cycle.
REQ-013 Port oBusy, output, 1: high in ROUND or EMIT state.

Function
REQ-014 The FSM SHALL have three states: COLLECT, ROUND and EMIT.
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both high.
REQ-016 COLLECT: oRxReady=1; each accepted byte shifts in MSB-first; byte 0 = V0[31:24] ... byte 7 = V1[7:0].
REQ-017 On the 8th accepted byte, the FSM SHALL go to ROUND, load sum = DELTA*ROUND_NUMBER mod 2^32 (32'hC6EF3720 at default), and register iK0..iK3.
REQ-018 Key changes after the 8th byte SHALL NOT affect the block in flight.
REQ-019 ROUND SHALL execute one round per cycle: v1 -= ((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3), then v0 -= ((v1new<<4)+k0)^(v1new+sum)^((v1new>>5)+k1), then sum -= DELTA.
REQ-020 All round arithmetic SHALL be modulo 2^WORD_SIZE; shifts are logical.
REQ-021 A round counter SHALL move the FSM to EMIT on the edge that completes round ROUND_NUMBER.
REQ-022 Latency: oTxValid SHALL first rise exactly ROUND_NUMBER cycles after the 8th-byte acceptance edge.
REQ-023 ROUND and EMIT: oRxReady SHALL be 0 and iRxData SHALL be ignored.
REQ-024 EMIT: oTxData SHALL present plaintext bytes in the order of REQ-016 (V0 MSB first).
REQ-025 EMIT: oTxValid SHALL stay 1 and oTxData stable until accepted; iTxReady low stalls indefinitely.
REQ-026 After the 8th byte is accepted, the FSM SHALL go to COLLECT with oRxReady=1 on the next cycle; there is no overlap between blocks.
REQ-027 Partial blocks SHALL wait indefinitely in COLLECT; there is no timeout.

Reset
REQ-028 On rst, the FSM SHALL enter COLLECT.
REQ-029 Reset values: byte count = 0, round counter = 0, oTxValid = 0, oTxData = 0, oBusy = 0, oRxReady = 1 on the first cycle after reset.
REQ-030 Reset SHALL abort any state mid-operation, including mid-ROUND and mid-EMIT, and discard the partial block.
REQ-031 rst SHALL have priority over any simultaneous transfer.

Structure
REQ-032 Package tea_pkg SHALL hold DELTA, ROUND_NUMBER, the derived initial-sum constant and the FSM state enum.
REQ-033 Sub-module tea_round_dec SHALL implement one combinational decipher round: inputs v0, v1, sum, k0..k3; outputs v0', v1'.
REQ-034 The FSM, the byte shift registers and the counters SHALL remain in tea_rx_decrypt.

Verification
REQ-035 Known vector: key all zero; bytes 41 EA 3A 0A 94 BA A9 40 -> eight 00 bytes out, first oTxValid 32 cycles after the 8th accept.
REQ-036 Round trip: key 132acf42/234acb45/3235acbe/4533f235; ciphertext of 3d45f7a7_235fcb21 from the TEA cipher core -> output bytes 3D 45 F7 A7 23 5F CB 21.
REQ-037 Backpressure: iTxReady=0 for 10 cycles in EMIT -> oTxValid held, oTxData unchanged, oRxReady=0; then all 8 bytes complete in order.
REQ-038 Gapped input: iRxValid toggled every other cycle -> same result as REQ-035; exactly 8 transfers counted.
REQ-039 Reset mid-ROUND at round 10 -> next cycle oBusy=0, oRxReady=1, no oTxValid; a fresh block then decrypts correctly.
REQ-040 Key change: iK0..iK3 modified during ROUND -> output equals the REQ-035 result computed with the registered key.
